// File: rtl/glob_cmd_pkg.sv
// Shared types for the global command issuer: command kinds, the packed
// command word carried through the FIFO, and the issue FSM states.
package glob_cmd_pkg;

  localparam int unsigned N_CTRL   = 4;
  localparam int unsigned TGT_W    = $clog2(N_CTRL);
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned ADDR_W   = 8;

  typedef enum logic [1:0] {
    CMD_DELAY    = 2'd0,
    CMD_PREFETCH = 2'd1,
    CMD_SCENARIO = 2'd2,
    CMD_RSVD     = 2'd3
  } cmd_type_e;

  typedef struct packed {
    cmd_type_e             kind;
    logic [TGT_W-1:0]      target;
    logic [SAMPLE_W-1:0]   delay;
    logic [ADDR_W-1:0]     dest;
    logic [SAMPLE_W-1:0]   pf_start;
    logic [SAMPLE_W-1:0]   pf_stop;
    logic [ADDR_W-1:0]     pf_dest;
  } cmd_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_GUARD = 1'b1
  } issue_state_e;

endpackage

// File: rtl/glob_cmd_issuer_if.sv
// Host command handshake plus the global-controller issue bus.
// The slave modport is the issuer; the master modport is the host side.
interface glob_cmd_issuer_if import glob_cmd_pkg::*; #(
  parameter int unsigned n_ctrl               = N_CTRL,
  parameter int unsigned sample_address_width = SAMPLE_W,
  parameter int unsigned address_vector_width = ADDR_W
);
  localparam int unsigned tgt_w = $clog2(n_ctrl);

  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [1:0]                      cmd_type;
  logic [tgt_w-1:0]                cmd_target;
  logic [sample_address_width-1:0] cmd_delay;
  logic [address_vector_width-1:0] cmd_dest;
  logic [sample_address_width-1:0] cmd_pf_start;
  logic [sample_address_width-1:0] cmd_pf_stop;
  logic [address_vector_width-1:0] cmd_pf_dest;

  logic [n_ctrl-1:0]               ctrl_valid;
  logic [n_ctrl-1:0]               prefetch_valid;
  logic [sample_address_width-1:0] glob_delay;
  logic [address_vector_width-1:0] glob_dest;
  logic [sample_address_width-1:0] glob_pf_start;
  logic [sample_address_width-1:0] glob_pf_stop;
  logic [address_vector_width-1:0] glob_pf_dest;
  logic                            scenario_update;
  logic                            err_reserved;
  logic                            busy;

  modport slave (
    input  cmd_valid, cmd_type, cmd_target, cmd_delay, cmd_dest,
           cmd_pf_start, cmd_pf_stop, cmd_pf_dest,
    output cmd_ready, ctrl_valid, prefetch_valid, glob_delay, glob_dest,
           glob_pf_start, glob_pf_stop, glob_pf_dest, scenario_update,
           err_reserved, busy
  );

  modport master (
    output cmd_valid, cmd_type, cmd_target, cmd_delay, cmd_dest,
           cmd_pf_start, cmd_pf_stop, cmd_pf_dest,
    input  cmd_ready, ctrl_valid, prefetch_valid, glob_delay, glob_dest,
           glob_pf_start, glob_pf_stop, glob_pf_dest, scenario_update,
           err_reserved, busy
  );

endinterface

// File: rtl/glob_cmd_fifo.sv
// Synchronous FIFO of packed commands. depth must be a power of 2 so the
// pointers wrap naturally. Head entry is presented combinationally on dout.
module glob_cmd_fifo import glob_cmd_pkg::*; #(
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     din,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = $clog2(depth) + 1;

  cmd_t          mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/glob_cmd_issuer.sv
// Global command issuer: buffers host commands and issues one per cycle
// as registered single-cycle pulses to the local prefetch controllers.
// A scenario broadcast forces guard_cycles idle cycles before the next issue.
module glob_cmd_issuer import glob_cmd_pkg::*; #(
  parameter int unsigned fifo_depth   = 4,
  parameter int unsigned guard_cycles = 2
) (
  input  logic              CLK,
  input  logic              reset,
  glob_cmd_issuer_if.slave  bus
);

  localparam int unsigned CW = $clog2(fifo_depth) + 1;
  localparam int unsigned GW = (guard_cycles > 1) ? $clog2(guard_cycles) : 1;

  cmd_t          in_cmd;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  issue_state_e  state;
  issue_state_e  state_nxt;
  logic [GW-1:0] gcnt;
  logic [GW-1:0] gcnt_nxt;

  assign in_cmd = '{
    kind:     cmd_type_e'(bus.cmd_type),
    target:   bus.cmd_target,
    delay:    bus.cmd_delay,
    dest:     bus.cmd_dest,
    pf_start: bus.cmd_pf_start,
    pf_stop:  bus.cmd_pf_stop,
    pf_dest:  bus.cmd_pf_dest
  };

  // Ready comes from the registered count, so a same-cycle pop never frees a slot.
  assign bus.cmd_ready = (count != CW'(fifo_depth));
  assign push          = bus.cmd_valid && !full;
  assign bus.busy      = !empty || (state == ST_GUARD);

  glob_cmd_fifo #(
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Issue FSM state and guard counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_RUN;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  // Pop decision and next state; the guard counter loads guard_cycles-1 so
  // GUARD lasts exactly guard_cycles cycles starting with the pulse cycle.
  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    pop       = 1'b0;
    case (state)
      ST_RUN: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.kind == CMD_SCENARIO && guard_cycles != 0) begin
            state_nxt = ST_GUARD;
            gcnt_nxt  = GW'(guard_cycles - 1);
          end
        end
      end
      ST_GUARD: begin
        if (gcnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          gcnt_nxt = gcnt - GW'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Registered issue outputs; data is zero whenever its valid is low.
  always_ff @(posedge CLK) begin
    bus.ctrl_valid      <= '0;
    bus.prefetch_valid  <= '0;
    bus.glob_delay      <= '0;
    bus.glob_dest       <= '0;
    bus.glob_pf_start   <= '0;
    bus.glob_pf_stop    <= '0;
    bus.glob_pf_dest    <= '0;
    bus.scenario_update <= 1'b0;
    bus.err_reserved    <= 1'b0;
    if (!reset && pop) begin
      case (head.kind)
        CMD_DELAY: begin
          bus.ctrl_valid[head.target] <= 1'b1;
          bus.glob_delay              <= head.delay;
          bus.glob_dest               <= head.dest;
        end
        CMD_PREFETCH: begin
          bus.prefetch_valid[head.target] <= 1'b1;
          bus.glob_pf_start               <= head.pf_start;
          bus.glob_pf_stop                <= head.pf_stop;
          bus.glob_pf_dest                <= head.pf_dest;
        end
        CMD_SCENARIO: bus.scenario_update <= 1'b1;
        default:      bus.err_reserved    <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_glob_cmd_issuer.sv
// Testbench for glob_cmd_issuer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_glob_cmd_issuer;
  import glob_cmd_pkg::*;

  localparam int GUARD = 2;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 CLK = ~CLK;

  glob_cmd_issuer_if bus ();

  glob_cmd_issuer #(
    .fifo_depth   (DEPTH),
    .guard_cycles (GUARD)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of pending commands and a count of idle cycles still owed.
  typedef struct {
    int unsigned kind, tgt, dly, dst, ps, pe, pd;
  } mcmd_t;

  mcmd_t      mq[$];
  int         guard_left = 0;
  bit         model_on = 0;
  logic [3:0] e_ctrl, e_pf;
  logic [7:0] e_dly, e_dst, e_ps, e_pe, e_pd;
  logic       e_scn, e_err, e_ready, e_busy;

  // Model advances on each rising edge from the inputs held since the falling edge.
  always @(posedge CLK) begin
    bit    acc;
    mcmd_t h;
    mcmd_t n;
    cyc++;
    e_ctrl = '0; e_pf = '0; e_dly = '0; e_dst = '0;
    e_ps = '0; e_pe = '0; e_pd = '0; e_scn = 1'b0; e_err = 1'b0;
    if (reset) begin
      mq.delete();
      guard_left = 0;
    end else begin
      acc = bus.cmd_valid && (mq.size() < DEPTH);
      n.kind = bus.cmd_type;     n.tgt = bus.cmd_target;
      n.dly  = bus.cmd_delay;    n.dst = bus.cmd_dest;
      n.ps   = bus.cmd_pf_start; n.pe  = bus.cmd_pf_stop;
      n.pd   = bus.cmd_pf_dest;
      if (guard_left > 0) begin
        guard_left--;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        case (h.kind)
          0: begin
            e_ctrl = 4'b0001 << h.tgt;
            e_dly = h.dly[7:0]; e_dst = h.dst[7:0];
          end
          1: begin
            e_pf = 4'b0001 << h.tgt;
            e_ps = h.ps[7:0]; e_pe = h.pe[7:0]; e_pd = h.pd[7:0];
          end
          2: begin
            e_scn = 1'b1;
            guard_left = GUARD;
          end
          default: e_err = 1'b1;
        endcase
      end
      if (acc) mq.push_back(n);
    end
    e_ready = (mq.size() < DEPTH);
    e_busy  = (mq.size() > 0) || (guard_left > 0);
    model_on = 1'b1;
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    if (model_on) begin
      chk("ctrl_valid",      bus.ctrl_valid,      e_ctrl);
      chk("prefetch_valid",  bus.prefetch_valid,  e_pf);
      chk("glob_delay",      bus.glob_delay,      e_dly);
      chk("glob_dest",       bus.glob_dest,       e_dst);
      chk("glob_pf_start",   bus.glob_pf_start,   e_ps);
      chk("glob_pf_stop",    bus.glob_pf_stop,    e_pe);
      chk("glob_pf_dest",    bus.glob_pf_dest,    e_pd);
      chk("scenario_update", bus.scenario_update, e_scn);
      chk("err_reserved",    bus.err_reserved,    e_err);
      chk("cmd_ready",       bus.cmd_ready,       e_ready);
      chk("busy",            bus.busy,            e_busy);
    end
  end

  task automatic drive(input int unsigned k, tg, d, ds, ps, pe, pd);
    bus.cmd_type     = 2'(k);
    bus.cmd_target   = 2'(tg);
    bus.cmd_delay    = 8'(d);
    bus.cmd_dest     = 8'(ds);
    bus.cmd_pf_start = 8'(ps);
    bus.cmd_pf_stop  = 8'(pe);
    bus.cmd_pf_dest  = 8'(pd);
    bus.cmd_valid    = 1'b1;
  endtask

  // One-cycle push attempt starting at a falling edge; reports acceptance.
  task automatic try_push(input int unsigned k, tg, d, ds, ps, pe, pd, output bit acc);
    drive(k, tg, d, ds, ps, pe, pd);
    acc = bus.cmd_ready;
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input string name, input int unsigned k, tg, d, ds, ps, pe, pd);
    bit acc;
    try_push(k, tg, d, ds, ps, pe, pd, acc);
    chk(name, acc, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctrl"}, bus.ctrl_valid, 0);
    chk({tag, "_pf"},   bus.prefetch_valid, 0);
    chk({tag, "_dly"},  bus.glob_delay, 0);
    chk({tag, "_pfd"},  bus.glob_pf_dest, 0);
    chk({tag, "_scn"},  bus.scenario_update, 0);
    chk({tag, "_err"},  bus.err_reserved, 0);
    chk({tag, "_rdy"},  bus.cmd_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [4:0]  acc_mask;
    int          k_scn;
    bit          seen;
    logic [7:0]  bp_dly [4];

    bus.cmd_valid = 1'b0;
    bus.cmd_type = '0; bus.cmd_target = '0; bus.cmd_delay = '0; bus.cmd_dest = '0;
    bus.cmd_pf_start = '0; bus.cmd_pf_stop = '0; bus.cmd_pf_dest = '0;
    bp_dly[0] = 8'h10; bp_dly[1] = 8'h21; bp_dly[2] = 8'h32; bp_dly[3] = 8'h43;

    // Reset held for three edges.
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    chk_idle_outputs("rst");
    chk("model_rst_ready", e_ready, 1);
    reset = 1'b0;
    @(negedge CLK);

    // Delay command; prefetch fields must not leak onto the bus.
    send("dly_acc", 0, 2, 'h19, 'h08, 'haa, 'hbb, 'hcc);
    @(negedge CLK);
    chk("dly_ctrl", bus.ctrl_valid, 4'b0100);
    chk("dly_data", bus.glob_delay, 8'h19);
    chk("dly_dest", bus.glob_dest, 8'h08);
    chk("dly_pf_gated", bus.glob_pf_start, 0);
    chk("model_dly_ctrl", e_ctrl, 4'b0100);
    @(negedge CLK);
    chk("dly_end_ctrl", bus.ctrl_valid, 0);
    chk("dly_end_data", bus.glob_delay, 0);

    // Prefetch windows, normal and wrapped.
    send("pf_acc", 1, 3, 'h55, 'h66, 'h30, 'he0, 'h6f);
    @(negedge CLK);
    chk("pf_valid", bus.prefetch_valid, 4'b1000);
    chk("pf_start", bus.glob_pf_start, 8'h30);
    chk("pf_stop",  bus.glob_pf_stop, 8'he0);
    chk("pf_dest",  bus.glob_pf_dest, 8'h6f);
    chk("pf_dly_gated", bus.glob_delay, 0);
    @(negedge CLK);
    chk("pf_end", bus.prefetch_valid, 0);
    send("pfw_acc", 1, 3, 0, 0, 'he0, 'h30, 'h6f);
    @(negedge CLK);
    chk("pfw_valid", bus.prefetch_valid, 4'b1000);
    chk("pfw_start", bus.glob_pf_start, 8'he0);
    chk("pfw_stop",  bus.glob_pf_stop, 8'h30);

    // Scenario followed directly by a delay command: spacing of 1+GUARD cycles.
    @(negedge CLK);
    send("scn_acc", 2, 1, 0, 0, 0, 0, 0);
    send("scn_dly_acc", 0, 1, 'h42, 'h24, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.scenario_update) seen = 1;
      else @(negedge CLK);
    end
    chk("scn_seen", seen, 1);
    k_scn = cyc;
    @(negedge CLK);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.ctrl_valid != 0) seen = 1;
      else @(negedge CLK);
    end
    chk("scn_dly_seen", seen, 1);
    chk("scn_spacing", 32'(cyc - k_scn), 3);
    chk("scn_dly_ctrl", bus.ctrl_valid, 4'b0010);
    chk("scn_dly_data", bus.glob_delay, 8'h42);

    // Reserved command is dropped with an error pulse.
    @(negedge CLK);
    send("rsv_acc", 3, 0, 'h11, 'h22, 'h33, 'h44, 'h55);
    @(negedge CLK);
    chk("rsv_err", bus.err_reserved, 1);
    chk("rsv_ctrl", bus.ctrl_valid, 0);
    chk("rsv_pf", bus.prefetch_valid, 0);
    chk("rsv_dly", bus.glob_delay, 0);
    @(negedge CLK);
    chk("rsv_err_end", bus.err_reserved, 0);

    // Back-pressure: two scenarios stall issue while five pushes are attempted.
    @(negedge CLK);
    send("bp_s1", 2, 0, 0, 0, 0, 0, 0);
    send("bp_s2", 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      try_push(0, i % 4, (i < 4) ? bp_dly[i] : 8'h54, 8'h80 + i, 0, 0, 0, acc);
      acc_mask[i] = acc;
    end
    chk("bp_accept_mask", acc_mask, 5'b01111);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("bp_order_ctrl", bus.ctrl_valid, 4'b0001 << i);
      chk("bp_order_dly", bus.glob_delay, bp_dly[i]);
    end
    @(negedge CLK);
    chk("bp_drained_ctrl", bus.ctrl_valid, 0);
    chk("bp_drained_busy", bus.busy, 0);

    // Reset in GUARD with two queued commands.
    @(negedge CLK);
    send("mr_scn", 2, 0, 0, 0, 0, 0, 0);
    send("mr_a", 0, 0, 'h01, 'h01, 0, 0, 0);
    send("mr_b", 0, 1, 'h02, 'h02, 0, 0, 0);
    chk("mr_busy_before", bus.busy, 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk_idle_outputs("mr");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("mr_quiet_ctrl", bus.ctrl_valid, 0);
      chk("mr_quiet_busy", bus.busy, 0);
    end
    send("mr_after_acc", 0, 3, 'h77, 'h88, 0, 0, 0);
    @(negedge CLK);
    chk("mr_after_ctrl", bus.ctrl_valid, 4'b1000);
    chk("mr_after_dly", bus.glob_delay, 8'h77);
    chk("mr_after_dest", bus.glob_dest, 8'h88);
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
